// File: rtl/xoro_bus_pkg.sv
// ---------------------------------------------------------------------------
// xoro_bus_pkg
// Shared definitions for the picorv32 native-bus fabric.
//   arb_state_t    : arbiter FSM states (IDLE / BUSY0 / BUSY1)
//   BUS_ERR_RDATA  : read data returned to a master whose transaction timed out
//   STRB_W         : byte write-strobe width of the native bus
// ---------------------------------------------------------------------------
package xoro_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] BUS_ERR_RDATA = 32'hDEADBEEF;
  localparam int          STRB_W        = 4;

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-master round-robin arbiter for the picorv32 native memory bus. Masters
// s0_/s1_ share a single downstream port m_ towards the memory controller.
// One transaction is in flight at a time; every transaction is followed by at
// least one IDLE cycle. Under contention grants alternate 0,1,0,1...
//
// Handshake (native bus): a master raises sn_valid with its request fields and
// holds them until sn_ready. sn_ready is a single-cycle completion pulse,
// combinational from m_ready in the same cycle. Dropping sn_valid before
// sn_ready aborts the transaction: the arbiter returns to IDLE, no ready.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   sN_valid/sN_ready     : master request / completion (N = 0,1)
//   sN_instr/wstrb/wdata/addr : master request fields
//   sN_rdata              : read data (m_rdata, qualified by sN_ready)
//   m_valid/m_ready       : downstream request / completion
//   m_instr/wstrb/wdata/addr : forwarded request fields of the granted master
//   m_rdata               : downstream read data
//   bus_err               : sticky timeout flag
//   state_dbg             : current arbiter state (arb_state_t encoding)
//
// Optional feature: define ARB_TIMEOUT_EN to enable the stall timeout. A
// granted transaction that sees no m_ready for TIMEOUT_CYCLES cycles is
// completed towards the master with BUS_ERR_RDATA and bus_err is set.
// Without the macro a stalled downstream hangs the granted master and bus_err
// is tied low.
// ---------------------------------------------------------------------------
module mem_arbiter
  import xoro_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic              s0_instr,
  input  logic [3:0]        s0_wstrb,
  input  logic [31:0]       s0_wdata,
  input  logic [ADDR_W-1:0] s0_addr,
  output logic [31:0]       s0_rdata,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic              s1_instr,
  input  logic [3:0]        s1_wstrb,
  input  logic [31:0]       s1_wdata,
  input  logic [ADDR_W-1:0] s1_addr,
  output logic [31:0]       s1_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_instr,
  output logic [3:0]        m_wstrb,
  output logic [31:0]       m_wdata,
  output logic [ADDR_W-1:0] m_addr,
  input  logic [31:0]       m_rdata,
  output logic              bus_err,
  output logic [1:0]        state_dbg
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t state;
  logic       last_grant;   // master that was granted most recently
  logic       busy0, busy1;
  logic       timeout_hit;  // granted transaction expires this cycle
  logic [31:0] rdata_mux;

  assign busy0     = (state == BUSY0);
  assign busy1     = (state == BUSY1);
  assign state_dbg = state;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // Only a master still waiting can time out; m_ready wins in the same cycle.
  assign timeout_hit = ((busy0 & s0_valid) | (busy1 & s1_valid)) & ~m_ready &
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero while IDLE, so it is clear on entry to BUSYn.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        cnt <= '0;
      end else if (!m_ready) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  // Arbiter FSM. On a tie the master that was not granted last wins; reset
  // value last_grant=1 lets master 0 win the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (s0_valid && (!s1_valid || last_grant)) begin
            state      <= BUSY0;
            last_grant <= 1'b0;
          end else if (s1_valid) begin
            state      <= BUSY1;
            last_grant <= 1'b1;
          end
        end
        BUSY0: begin
          if (m_ready || !s0_valid || timeout_hit) state <= IDLE;
        end
        BUSY1: begin
          if (m_ready || !s1_valid || timeout_hit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Downstream request mux: fields of the granted master, all zero when IDLE.
  always_comb begin
    m_valid = 1'b0;
    m_instr = 1'b0;
    m_wstrb = '0;
    m_wdata = '0;
    m_addr  = '0;
    case (state)
      BUSY0: begin
        m_valid = s0_valid;
        m_instr = s0_instr;
        m_wstrb = s0_wstrb;
        m_wdata = s0_wdata;
        m_addr  = s0_addr;
      end
      BUSY1: begin
        m_valid = s1_valid;
        m_instr = s1_instr;
        m_wstrb = s1_wstrb;
        m_wdata = s1_wdata;
        m_addr  = s1_addr;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own ready.
  assign rdata_mux = timeout_hit ? BUS_ERR_RDATA : m_rdata;
  assign s0_rdata  = rdata_mux;
  assign s1_rdata  = rdata_mux;
  assign s0_ready  = busy0 & (m_ready | timeout_hit);
  assign s1_ready  = busy1 & (m_ready | timeout_hit);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: a small word memory model answers the
// downstream port in the same cycle it sees m_valid (can be stalled with
// mem_en=0), master tasks drive s0_/s1_, a negedge monitor records the
// completion order and the m_valid idle gaps.
// Build with +define+ARB_TIMEOUT_EN to exercise the timeout (TIMEOUT_CYCLES=4).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        s0_valid, s0_ready, s0_instr;
  logic [3:0]  s0_wstrb;
  logic [31:0] s0_wdata, s0_addr, s0_rdata;
  logic        s1_valid, s1_ready, s1_instr;
  logic [3:0]  s1_wstrb;
  logic [31:0] s1_wdata, s1_addr, s1_rdata;
  logic        m_valid, m_ready, m_instr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata, m_addr, m_rdata;
  logic        bus_err;
  logic [1:0]  state_dbg;

  mem_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_instr(s0_instr),
    .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata), .s0_addr(s0_addr), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_instr(s1_instr),
    .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata), .s1_addr(s1_addr), .s1_rdata(s1_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_instr(m_instr), .m_wstrb(m_wstrb),
    .m_wdata(m_wdata), .m_addr(m_addr), .m_rdata(m_rdata),
    .bus_err(bus_err), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // downstream memory model: 16 words, answers at posedge+2 while m_valid
  logic [31:0] mem [0:15];
  bit          mem_en = 1'b1;

  initial begin
    logic [3:0] idx;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      m_ready = 1'b0;
      if (mem_en && m_valid) begin
        m_ready = 1'b1;
        idx = m_addr[5:2];
        if (m_wstrb != 4'b0000) begin
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          m_rdata = mem[idx];
        end
      end
    end
  end

  // monitor: completion order and m_valid low-run lengths before each request
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          gap_q[$];
  int          low_run = 0;
  logic        prev_mv = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (s0_ready) got_q.push_back(32'd0);
      if (s1_ready) got_q.push_back(32'd1);
      if (m_valid && !prev_mv) gap_q.push_back(low_run);
      low_run = m_valid ? 0 : low_run + 1;
      prev_mv = m_valid;
    end
  end

  // driver tasks
  task automatic drive_req(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr);
    if (id == 0) begin
      s0_valid = 1'b1; s0_addr = addr; s0_wdata = wdata; s0_wstrb = wstrb; s0_instr = instr;
    end else begin
      s1_valid = 1'b1; s1_addr = addr; s1_wdata = wdata; s1_wstrb = wstrb; s1_instr = instr;
    end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) begin
      s0_valid = 1'b0; s0_addr = '0; s0_wdata = '0; s0_wstrb = '0; s0_instr = 1'b0;
    end else begin
      s1_valid = 1'b0; s1_addr = '0; s1_wdata = '0; s1_wstrb = '0; s1_instr = 1'b0;
    end
  endtask

  // Returns at the negedge where ready is seen (bounded to 40 cycles).
  task automatic wait_ready(input int id, output logic [31:0] rdata, output logic ok);
    ok = 1'b0;
    rdata = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id == 0) ? s0_ready : s1_ready) begin
        rdata = (id == 0) ? s0_rdata : s1_rdata;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic master_loop(input int id);
    logic [31:0] rd;
    logic        ok;
    for (int k = 0; k < 4; k++) begin
      drive_req(id, 32'h40 + 32'(k * 8 + id * 4), 32'h0, 4'h0, 1'b0);
      wait_ready(id, rd, ok);
      check($sformatf("t3_done_m%0d_%0d", id, k), 32'(ok), 32'd1);
      @(posedge clk); #1;
    end
    drop_req(id);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] rd;
    logic        ok;
    int          n0;

    drop_req(0);
    drop_req(1);
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4]  = 32'h12345678;
    mem[12] = 32'h11223344;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_ready", 32'({s0_ready, s1_ready}), 32'd0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // T1: single read from master 0, one-cycle arbitration latency
    drive_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    check("t1_mvalid_lat", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t1_mvalid", 32'(m_valid), 32'd1);
    check("t1_maddr", m_addr, 32'h10);
    check("t1_s0_ready", 32'(s0_ready), 32'd1);
    check("t1_s0_rdata", s0_rdata, 32'h12345678);
    check("t1_s1_ready", 32'(s1_ready), 32'd0);
    @(posedge clk); #1 drop_req(0);
    @(negedge clk);
    check("t1_idle", 32'(state_dbg), 32'd0);

    // T2: simultaneous requests after reset, master 0 wins
    reset_dut();
    got_q.delete();
    drive_req(0, 32'h20, 32'hAABBCCDD, 4'hF, 1'b0);
    drive_req(1, 32'h20, 32'h0, 4'h0, 1'b0);
    wait_ready(0, rd, ok);
    check("t2_s0_done", 32'(ok), 32'd1);
    check("t2_m_wdata", m_wdata, 32'hAABBCCDD);
    check("t2_m_wstrb", 32'(m_wstrb), 32'hF);
    check("t2_s1_ready", 32'(s1_ready), 32'd0);
    @(posedge clk); #1 drop_req(0);
    wait_ready(1, rd, ok);
    check("t2_s1_done", 32'(ok), 32'd1);
    check("t2_s1_rdata", rd, 32'hAABBCCDD);
    check("t2_first", got_q.size() > 0 ? got_q[0] : 32'hFFFF_FFFF, 32'd0);
    @(posedge clk); #1 drop_req(1);

    // T3: continuous contention, 8 transactions alternate with one idle cycle
    got_q.delete();
    gap_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i % 2));
    fork
      master_loop(0);
      master_loop(1);
    join
    check("t3_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_grant%0d", i), (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, exp_q[i]);
    check("t3_gap_count", 32'(gap_q.size()), 32'd8);
    for (int i = 1; i < 8; i++)
      check($sformatf("t3_gap%0d", i), (i < gap_q.size()) ? 32'(gap_q[i]) : 32'hFFFF_FFFF, 32'd1);

    // T4: byte write from master 1, then instruction-flagged readback
    @(posedge clk); #1;
    drive_req(1, 32'h30, 32'h00EE0000, 4'b0100, 1'b0);
    wait_ready(1, rd, ok);
    check("t4_w_done", 32'(ok), 32'd1);
    check("t4_m_wstrb", 32'(m_wstrb), 32'h4);
    check("t4_m_addr", m_addr, 32'h30);
    @(posedge clk); #1 drop_req(1);
    drive_req(1, 32'h30, 32'h0, 4'h0, 1'b1);
    wait_ready(1, rd, ok);
    check("t4_m_instr", 32'(m_instr), 32'd1);
    check("t4_rdata", rd, 32'h11EE3344);
    @(posedge clk); #1 drop_req(1);

    // T5: reset while BUSY0 with downstream stalled
    mem_en = 1'b0;
    n0 = got_q.size();
    drive_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t5_busy0", 32'(state_dbg), 32'd1);
    check("t5_mvalid", 32'(m_valid), 32'd1);
    reset = 1'b1;
    drop_req(0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t5_rst_idle", 32'(state_dbg), 32'd0);
    check("t5_rst_mvalid", 32'(m_valid), 32'd0);
    check("t5_no_ready", 32'(got_q.size()), 32'(n0));
    mem_en = 1'b1;
    @(posedge clk); #1;
    drive_req(1, 32'h20, 32'h0, 4'h0, 1'b0);
    wait_ready(1, rd, ok);
    check("t5_s1_done", 32'(ok), 32'd1);
    check("t5_s1_rdata", rd, 32'hAABBCCDD);
    @(posedge clk); #1 drop_req(1);

    // T6: abort, master 0 drops valid while stalled
    mem_en = 1'b0;
    n0 = got_q.size();
    drive_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 drop_req(0);
    @(negedge clk);
    check("t6_mvalid", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t6_idle", 32'(state_dbg), 32'd0);
    check("t6_no_ready", 32'(got_q.size()), 32'(n0));
    mem_en = 1'b1;

`ifdef ARB_TIMEOUT_EN
    // T7: timeout after 4 stalled BUSY cycles
    reset_dut();
    mem_en = 1'b0;
    drive_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t7_ready_c%0d", c), 32'(s0_ready), (c == 4) ? 32'd1 : 32'd0);
      if (c == 4) check("t7_rdata", s0_rdata, 32'hDEADBEEF);
    end
    @(posedge clk); #1 drop_req(0);
    @(negedge clk);
    check("t7_bus_err", 32'(bus_err), 32'd1);
    check("t7_idle", 32'(state_dbg), 32'd0);
    repeat (3) @(negedge clk);
    check("t7_bus_err_sticky", 32'(bus_err), 32'd1);
    mem_en = 1'b1;
`else
    // T7: without the timeout a stalled downstream holds the grant
    reset_dut();
    mem_en = 1'b0;
    n0 = got_q.size();
    drive_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
    repeat (12) @(negedge clk);
    check("t7_still_busy", 32'(state_dbg), 32'd1);
    check("t7_no_ready", 32'(got_q.size()), 32'(n0));
    check("t7_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1 drop_req(0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t7_idle", 32'(state_dbg), 32'd0);
    mem_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master round-robin arbiter for the picorv32 native memory bus.
- Sits directly upstream of the on-chip memory controller: two cores (or core + DMA) on ports s0_/s1_, single forwarded bus on m_ → memory controller.
- Serialises transactions, steers rdata/ready back to the granted master, guarantees fairness under contention.

Parameters:
- ADDR_W, 32, address width forwarded to downstream.
- TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for m_ready (used only with ARB_TIMEOUT_EN); min 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- s0_valid/s1_valid  in  1  master request.
- s0_ready/s1_ready  out  1  transaction complete to master.
- s0_instr/s1_instr  in  1  instruction fetch flag.
- s0_wstrb/s1_wstrb  in  4  byte write strobes (0 = read).
- s0_wdata/s1_wdata  in  32  write data.
- s0_addr/s1_addr  in  ADDR_W  byte address.
- s0_rdata/s1_rdata  out  32  read data.
- m_valid  out  1  downstream request.
- m_ready  in  1  downstream completion.
- m_instr  out  1, m_wstrb  out  4, m_wdata  out  32, m_addr  out  ADDR_W  forwarded request fields.
- m_rdata  in  32  downstream read data.
- bus_err  out  1  sticky timeout flag (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registers: state, last_grant (1 bit), timeout counter (optional).
- Reset: state=IDLE, last_grant=1 (master 0 wins the first tie), bus_err=0, counter=0. All outputs combinational from state: m_valid=0, s0/s1_ready=0, m_addr/m_wdata/m_wstrb/m_instr=0.
- IDLE: only s0_valid → BUSY0. Only s1_valid → BUSY1. Both → grant the master != last_grant. On entering BUSYn, last_grant <= n.
- Arbitration latency: exactly 1 cycle. m_valid first asserts the cycle after the request is sampled.
- BUSYn forwarding:
  - m_valid = sn_valid.
  - m_addr/m_wdata/m_wstrb/m_instr = master n fields; other master's fields ignored.
  - m_addr is passed through unmodified (word select is the memory's job).
- Completion: sn_ready = (state==BUSYn) & m_ready, combinational, same cycle. Non-granted ready is always 0. sn_rdata = m_rdata for both masters (qualified by ready).
- BUSYn with m_ready=1 → IDLE next posedge. No back-to-back grant without an IDLE cycle: minimum 1 idle cycle between transactions.
- Abort: sn_valid drops in BUSYn without m_ready → IDLE next posedge, no ready issued.
- m_ready while IDLE is ignored.
- Fairness: under continuous requests from both, grants alternate 0,1,0,1…; neither master waits more than one transaction.
- Reset mid-transaction: state forced IDLE on that posedge; in-flight write may already have committed downstream; no ready returned.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to BUSYn and increments each BUSYn cycle without m_ready.
  - When counter == TIMEOUT_CYCLES-1 and m_ready still 0: assert sn_ready for one cycle with sn_rdata=32'hDEADBEEF, set bus_err (sticky until reset), → IDLE.
  - m_ready in the same cycle takes precedence (normal completion, no error).
- Undefined: no counter; a stalled downstream hangs the granted master indefinitely; bus_err=0.

Decomposition:
- Shared package xoro_bus_pkg: arbiter state enum (IDLE/BUSY0/BUSY1), BUS_ERR_RDATA=32'hDEADBEEF, strobe width constant 4.
- No sub-module needed; state machine, mux and counter are one module. Any 2:1 mux helper stays inline.

Test Plan:
- Single read: s0_valid, addr 0x10, wstrb 0; memory returns 0x12345678 → m_valid high 1 cycle after request, s0_ready with s0_rdata=0x12345678, s1_ready stays 0.
- Simultaneous requests after reset: s0 write 0xAABBCCDD@0x20, s1 read@0x20 → s0 served first; s1 then reads 0xAABBCCDD.
- Continuous contention for 8 transactions → grant order 0,1,0,1,0,1,0,1; m_valid low exactly 1 cycle between each.
- Byte write: s1 wstrb=4'b0100, wdata=0x00EE0000@0x30 → m_wstrb=4'b0100 forwarded; readback shows only byte 2 changed.
- Reset asserted in BUSY0 before m_ready → next cycle state IDLE, m_valid=0, no s0_ready; s1 request afterwards served normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, m_ready held 0 → s0_ready on 4th BUSY cycle, s0_rdata=0xDEADBEEF, bus_err=1 and stays 1.
